// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the sequenced shifter arbiter
package shift_pkg;

  localparam int W_DATA = 8;
  localparam int W_AMT  = 4;
  localparam logic [2:0] MAX_STEP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Largest pass the 3-bit shifter can take out of the remaining amount
  function automatic logic [2:0] pass_step(input logic [W_AMT-1:0] rem);
    return (rem > {1'b0, MAX_STEP}) ? MAX_STEP : rem[2:0];
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational 8-bit shifter, 0..7 bits per use
module barrel_shifter
  import shift_pkg::*;
(
  input  logic [W_DATA-1:0] din,
  input  logic [2:0]        shamt,
  input  logic              LR,
  input  logic              AL,
  output logic [W_DATA-1:0] dout
);

  // Left ignores AL; right arithmetic replicates bit7
  always_comb begin
    if (LR) begin
      dout = din << shamt;
    end else if (AL) begin
      dout = $signed(din) >>> shamt;
    end else begin
      dout = din >> shamt;
    end
  end

endmodule

// File: rtl/shift_arbiter_seq.sv
// rtl/shift_arbiter_seq.sv - round-robin sharing of one shifter, multi-pass sequencing
module shift_arbiter_seq
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_din,
  input  logic [7:0]  req_amt,
  input  logic [1:0]  req_lr,
  input  logic [1:0]  req_al,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_data,
  output logic        resp_id
);

  state_t             state;
  logic               rr_ptr;
  logic [W_DATA-1:0]  acc;
  logic [W_AMT-1:0]   rem;
  logic               lr_q;
  logic               al_q;
  logic               id_q;

  logic               any_valid;
  logic               grant;
  logic [2:0]         step;
  logic [W_AMT-1:0]   rem_next;
  logic [W_DATA-1:0]  shifted;

  // Grant the pointer-favoured requester if it is asking, otherwise the other one
  always_comb begin
    any_valid = |req_valid;
    grant     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    req_ready = 2'b00;
    if (state == IDLE && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Per-pass amount and what is left afterwards
  always_comb begin
    step     = pass_step(rem);
    rem_next = rem - {1'b0, step};
  end

  barrel_shifter u_shifter (
    .din   (acc),
    .shamt (step),
    .LR    (lr_q),
    .AL    (al_q),
    .dout  (shifted)
  );

  // Control FSM: accept one request, shift it in passes, hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      acc        <= '0;
      rem        <= '0;
      lr_q       <= 1'b0;
      al_q       <= 1'b0;
      id_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            acc    <= grant ? req_din[15:8] : req_din[7:0];
            rem    <= grant ? req_amt[7:4]  : req_amt[3:0];
            lr_q   <= req_lr[grant];
            al_q   <= req_al[grant];
            id_q   <= grant;
            rr_ptr <= ~grant;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= shifted;
          rem <= rem_next;
          // amt 0 still spends one pass with a zero step
          if (rem_next == '0) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= shifted;
            resp_id    <= id_q;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// tb/tb_shift_arbiter_seq.sv - randomized self-checking bench for shift_arbiter_seq
module tb_shift_arbiter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_din;
  logic [7:0]  req_amt;
  logic [1:0]  req_lr;
  logic [1:0]  req_al;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic        resp_id;

  int errors = 0;
  int checks = 0;

  logic [7:0] op_din [2];
  logic [3:0] op_amt [2];
  logic       op_lr  [2];
  logic       op_al  [2];
  logic       mptr;

  shift_arbiter_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_din    (req_din),
    .req_amt    (req_amt),
    .req_lr     (req_lr),
    .req_al     (req_al),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-amount shift done in one go on wide integers
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                           input logic lr, input logic al);
    int v;
    if (lr)      v = int'(d) << amt;
    else if (al) v = int'($signed(d)) >>> amt;
    else         v = int'(d) >> amt;
    return v[7:0];
  endfunction

  function automatic int ref_passes(input int amt);
    return (amt == 0) ? 1 : (amt + 6) / 7;
  endfunction

  task automatic set_op(input int id, input logic [7:0] d, input logic [3:0] a,
                        input logic lr, input logic al);
    op_din[id] = d;
    op_amt[id] = a;
    op_lr[id]  = lr;
    op_al[id]  = al;
  endtask

  task automatic rand_op(input int id);
    set_op(id, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_ops(input logic [1:0] mask);
    req_valid = mask;
    req_din   = {op_din[1], op_din[0]};
    req_amt   = {op_amt[1], op_amt[0]};
    req_lr    = {op_lr[1], op_lr[0]};
    req_al    = {op_al[1], op_al[0]};
  endtask

  // Called just after a negedge with the DUT idle; returns the same way
  task automatic txn(input logic [1:0] mask, input int hold, input bit keep);
    logic       g;
    logic [7:0] exp_data;
    int         passes;
    int         n;
    drive_ops(mask);
    resp_ready = (hold == 0);
    #1;
    g = mask[mptr] ? mptr : ~mptr;
    check("grant", req_ready, 32'(2'b01 << g));
    exp_data = ref_shift(op_din[g], op_amt[g], op_lr[g], op_al[g]);
    passes   = ref_passes(op_amt[g]);
    mptr     = ~g;
    @(negedge clk);
    rand_op(g);
    drive_ops(keep ? mask : 2'b00);
    #1;
    n = 0;
    while (!resp_valid && n < 30) begin
      check("busy_ready", req_ready, 0);
      @(negedge clk);
      #1;
      n++;
    end
    check("latency", n, passes);
    check("data", resp_data, exp_data);
    check("id", resp_id, g);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, exp_data);
      check("hold_id", resp_id, g);
      check("hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("done_one_cycle", resp_valid, 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_din    = '0;
    req_amt    = '0;
    req_lr     = '0;
    req_al     = '0;
    resp_ready = 1'b0;
    mptr       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    set_op(0, 8'hB4, 4'd3, 1'b0, 1'b1);
    set_op(1, 8'h00, 4'd0, 1'b0, 1'b0);
    txn(2'b01, 0, 0);
    set_op(1, 8'h81, 4'd10, 1'b1, 1'b0);
    txn(2'b10, 0, 0);
    set_op(0, 8'h80, 4'd15, 1'b0, 1'b1);
    txn(2'b01, 0, 0);
    set_op(0, 8'h80, 4'd15, 1'b0, 1'b0);
    txn(2'b10, 0, 0);
    set_op(1, 8'h80, 4'd15, 1'b0, 1'b0);
    txn(2'b10, 0, 0);
    set_op(0, 8'h3C, 4'd7, 1'b0, 1'b1);
    txn(2'b01, 5, 0);
    set_op(0, 8'hC3, 4'd8, 1'b0, 1'b1);
    txn(2'b01, 0, 0);
    set_op(1, 8'h5A, 4'd0, 1'b1, 1'b1);
    txn(2'b10, 0, 0);

    // both requesters continuously valid
    rand_op(0);
    rand_op(1);
    for (int i = 0; i < 6; i++) txn(2'b11, 0, 1);
    req_valid = 2'b00;
    @(negedge clk);

    // reset in the middle of a 3-pass shift
    set_op(0, 8'h80, 4'd15, 1'b0, 1'b1);
    drive_ops(2'b01);
    #1;
    check("pre_rst_grant", req_ready, 32'(2'b01 << mptr));
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_data", resp_data, 0);
    check("mid_rst_resp_id", resp_id, 0);
    check("mid_rst_req_ready", req_ready, 0);
    mptr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_resp", resp_valid, 0);
    end
    rand_op(0);
    rand_op(1);
    txn(2'b11, 0, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      rand_op(0);
      rand_op(1);
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
